// File: rtl/cmat_ram_bank.sv
// Operand bank for an N x N complex matrix product: loads M1/M2
// row-major, then streams (row i of M1, column j of M2) beat pairs.
module cmat_ram_bank #(
   parameter int WORD_LEN   = 16,
   parameter int MATRIX_DIM = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clr,
   input  logic                           wr_valid,
   output logic                           wr_ready,
   input  logic                           wr_sel,
   input  logic [WORD_LEN-1:0]            wr_re,
   input  logic [WORD_LEN-1:0]            wr_im,
   output logic                           m1_full,
   output logic                           m2_full,
   input  logic                           start,
   output logic                           busy,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [WORD_LEN*MATRIX_DIM-1:0] out_m1_re,
   output logic [WORD_LEN*MATRIX_DIM-1:0] out_m1_im,
   output logic [WORD_LEN*MATRIX_DIM-1:0] out_m2_re,
   output logic [WORD_LEN*MATRIX_DIM-1:0] out_m2_im,
   output logic [$clog2(MATRIX_DIM)-1:0]  out_row,
   output logic [$clog2(MATRIX_DIM)-1:0]  out_col,
   output logic                           out_last
);

   localparam int NN = MATRIX_DIM * MATRIX_DIM;
   localparam int IW = $clog2(MATRIX_DIM);
   localparam int CW = $clog2(NN);
   localparam int RW = WORD_LEN * MATRIX_DIM;
   localparam logic [CW-1:0] LAST_ADDR = CW'(NN - 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(MATRIX_DIM - 1);

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   state_t state_q, state_d;

   logic [WORD_LEN-1:0] m1_re_mem [NN];
   logic [WORD_LEN-1:0] m1_im_mem [NN];
   logic [WORD_LEN-1:0] m2_re_mem [NN];
   logic [WORD_LEN-1:0] m2_im_mem [NN];

   logic [CW-1:0] m1_cnt, m2_cnt;
   logic          wr_fire;
   logic          load;
   logic [IW-1:0] nxt_i, nxt_j;
   logic [RW-1:0] row_re, row_im, col_re, col_im;

   function automatic logic [CW-1:0] addr(input int r, input int c);
      return CW'(r * MATRIX_DIM + c);
   endfunction

   assign busy     = (state_q == STREAM);
   assign wr_ready = (state_q == IDLE) &&
                     !(wr_sel ? m2_full : m1_full);
   assign wr_fire  = wr_valid && wr_ready && !clr;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      nxt_i   = out_row;
      nxt_j   = out_col;
      unique case (state_q)
         IDLE: begin
            if (start && m1_full && m2_full && !clr) begin
               state_d = STREAM;
               load    = 1'b1;
               nxt_i   = '0;
               nxt_j   = '0;
            end
         end
         STREAM: begin
            if (clr) begin
               state_d = IDLE;
            end else if (out_valid && out_ready) begin
               if (out_last) begin
                  state_d = IDLE;
               end else begin
                  load = 1'b1;
                  if (out_col == LAST_IDX) begin
                     nxt_j = '0;
                     nxt_i = out_row + 1'b1;
                  end else begin
                     nxt_j = out_col + 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Gather row nxt_i of M1 and column nxt_j of M2 for the next beat
   always_comb begin
      row_re = '0;
      row_im = '0;
      col_re = '0;
      col_im = '0;
      for (int k = 0; k < MATRIX_DIM; k++) begin
         row_re[k*WORD_LEN +: WORD_LEN] = m1_re_mem[addr(int'(nxt_i), k)];
         row_im[k*WORD_LEN +: WORD_LEN] = m1_im_mem[addr(int'(nxt_i), k)];
         col_re[k*WORD_LEN +: WORD_LEN] = m2_re_mem[addr(k, int'(nxt_j))];
         col_im[k*WORD_LEN +: WORD_LEN] = m2_im_mem[addr(k, int'(nxt_j))];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         if (!wr_sel) begin
            m1_re_mem[m1_cnt] <= wr_re;
            m1_im_mem[m1_cnt] <= wr_im;
         end else begin
            m2_re_mem[m2_cnt] <= wr_re;
            m2_im_mem[m2_cnt] <= wr_im;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         m1_cnt  <= '0;
         m2_cnt  <= '0;
         m1_full <= 1'b0;
         m2_full <= 1'b0;
      end else if (wr_fire) begin
         if (!wr_sel) begin
            if (m1_cnt == LAST_ADDR) begin
               m1_cnt  <= '0;
               m1_full <= 1'b1;
            end else begin
               m1_cnt <= m1_cnt + 1'b1;
            end
         end else begin
            if (m2_cnt == LAST_ADDR) begin
               m2_cnt  <= '0;
               m2_full <= 1'b1;
            end else begin
               m2_cnt <= m2_cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_row   <= '0;
         out_col   <= '0;
         out_m1_re <= '0;
         out_m1_im <= '0;
         out_m2_re <= '0;
         out_m2_im <= '0;
      end else begin
         out_valid <= (state_d == STREAM);
         if (load) begin
            out_row   <= nxt_i;
            out_col   <= nxt_j;
            out_last  <= (nxt_i == LAST_IDX) && (nxt_j == LAST_IDX);
            out_m1_re <= row_re;
            out_m1_im <= row_im;
            out_m2_re <= col_re;
            out_m2_im <= col_im;
         end else if (state_d != STREAM) begin
            out_last <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cmat_ram_bank.sv
// Scoreboard bench for cmat_ram_bank (N=2): random loads, streams
// under varied backpressure, reset/clear aborts.
module tb_cmat_ram_bank;

   localparam int W  = 16;
   localparam int N  = 2;
   localparam int NN = N * N;
   localparam int IW = 1;
   localparam int RW = W * N;

   logic          clk = 1'b0;
   logic          rst, clr, wr_valid, wr_sel, start, out_ready;
   logic [W-1:0]  wr_re, wr_im;
   logic          wr_ready, m1_full, m2_full, busy, out_valid;
   logic [RW-1:0] out_m1_re, out_m1_im, out_m2_re, out_m2_im;
   logic [IW-1:0] out_row, out_col;
   logic          out_last;

   typedef struct {
      logic [IW-1:0] row;
      logic [IW-1:0] col;
      logic [RW-1:0] m1re;
      logic [RW-1:0] m1im;
      logic [RW-1:0] m2re;
      logic [RW-1:0] m2im;
      logic          last;
   } beat_t;

   beat_t        q[$];
   logic [W-1:0] mre[2][NN];
   logic [W-1:0] mim[2][NN];
   int           cnt[2];
   bit           mfull[2];
   int           passed = 0;
   int           total  = 0;
   bit           stall_prev = 1'b0;
   beat_t        snap;

   cmat_ram_bank #(.WORD_LEN(W), .MATRIX_DIM(N)) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel),
      .wr_re(wr_re), .wr_im(wr_im),
      .m1_full(m1_full), .m2_full(m2_full),
      .start(start), .busy(busy),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_m1_re(out_m1_re), .out_m1_im(out_m1_im),
      .out_m2_re(out_m2_re), .out_m2_im(out_m2_im),
      .out_row(out_row), .out_col(out_col), .out_last(out_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h required %0h", name, got, exp);
   endtask

   task automatic model_clear();
      mfull[0] = 1'b0;
      mfull[1] = 1'b0;
      cnt[0]   = 0;
      cnt[1]   = 0;
   endtask

   // Expected stream: every (i,j) pair, j fastest
   task automatic push_beats();
      beat_t b;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            b.row  = IW'(i);
            b.col  = IW'(j);
            b.last = (i == N - 1) && (j == N - 1);
            for (int k = 0; k < N; k++) begin
               b.m1re[k*W +: W] = mre[0][i*N + k];
               b.m1im[k*W +: W] = mim[0][i*N + k];
               b.m2re[k*W +: W] = mre[1][k*N + j];
               b.m2im[k*W +: W] = mim[1][k*N + j];
            end
            q.push_back(b);
         end
      end
   endtask

   always @(negedge clk) begin
      beat_t e;
      if (stall_prev) begin
         chk("stall_valid", out_valid, 1);
         chk("stall_row", out_row, snap.row);
         chk("stall_col", out_col, snap.col);
         chk("stall_m1re", out_m1_re, snap.m1re);
         chk("stall_m2im", out_m2_im, snap.m2im);
         chk("stall_last", out_last, snap.last);
      end
      stall_prev = 1'b0;
      if (!rst && !clr && out_valid) begin
         if (out_ready) begin
            if (q.size() == 0) begin
               total++;
               $display("FAIL beat_unexpected: got row %0d col %0d, required no beat",
                        out_row, out_col);
            end else begin
               e = q.pop_front();
               chk("beat_row", out_row, e.row);
               chk("beat_col", out_col, e.col);
               chk("beat_m1re", out_m1_re, e.m1re);
               chk("beat_m1im", out_m1_im, e.m1im);
               chk("beat_m2re", out_m2_re, e.m2re);
               chk("beat_m2im", out_m2_im, e.m2im);
               chk("beat_last", out_last, e.last);
            end
         end else begin
            stall_prev = 1'b1;
            snap.row   = out_row;
            snap.col   = out_col;
            snap.m1re  = out_m1_re;
            snap.m2im  = out_m2_im;
            snap.last  = out_last;
         end
      end
   end

   // One idle-state cycle: optional write, start and clr together
   task automatic step(input bit wv, input bit sel,
                       input logic [W-1:0] re, input logic [W-1:0] im,
                       input bit st, input bit cl);
      bit exp_rdy, acc;
      wr_valid = wv;
      wr_sel   = sel;
      wr_re    = re;
      wr_im    = im;
      start    = st;
      clr      = cl;
      exp_rdy  = !mfull[sel];
      #1 chk("wr_ready", wr_ready, exp_rdy);
      acc = st && mfull[0] && mfull[1] && !cl;
      if (acc) push_beats();
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      start    = 1'b0;
      clr      = 1'b0;
      if (cl) begin
         model_clear();
      end else if (wv && exp_rdy) begin
         mre[sel][cnt[sel]] = re;
         mim[sel][cnt[sel]] = im;
         cnt[sel]++;
         if (cnt[sel] == NN) begin
            cnt[sel]   = 0;
            mfull[sel] = 1'b1;
         end
      end
      chk("start_valid", out_valid, acc);
      chk("start_busy", busy, acc);
      chk("m1_full", m1_full, mfull[0]);
      chk("m2_full", m2_full, mfull[1]);
   endtask

   task automatic drain(input int mode, input int want);
      int cyc  = 0;
      int held = 0;
      wr_valid = 1'b1;
      wr_sel   = 1'($urandom);
      wr_re    = W'($urandom);
      wr_im    = W'($urandom);
      #1 chk("wr_ready_stream", wr_ready, 0);
      while (q.size() > 0 && cyc < 200) begin
         case (mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom % 3) != 0;
            default: begin
               if (out_valid && out_row == 1 && out_col == 0 && held < 3) begin
                  out_ready = 1'b0;
                  held++;
               end else begin
                  out_ready = 1'b1;
               end
            end
         endcase
         @(posedge clk);
         #1;
         wr_valid = 1'b0;
         cyc++;
      end
      out_ready = 1'b0;
      if (q.size() > 0) begin
         total++;
         $display("FAIL drain_timeout: got %0d beats left, required 0", q.size());
         q.delete();
      end
      chk("drain_valid", out_valid, 0);
      chk("drain_busy", busy, 0);
      chk("full_kept", {m1_full, m2_full}, {mfull[0], mfull[1]});
      if (want >= 0) chk("drain_cycles", cyc, want);
   endtask

   task automatic load_rand();
      int n = 0;
      while (!(mfull[0] && mfull[1]) && n < 100) begin
         step(($urandom % 4) != 0, 1'($urandom), W'($urandom),
              W'($urandom), 1'b0, 1'b0);
         n++;
      end
      if (!(mfull[0] && mfull[1])) begin
         total++;
         $display("FAIL load_timeout: got full %0b%0b, required 11", mfull[0], mfull[1]);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; clr = 1'b0; start = 1'b0; out_ready = 1'b0;
      wr_valid = 1'b0; wr_sel = 1'b0; wr_re = '0; wr_im = '0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_full", {m1_full, m2_full}, 0);
      chk("rst_last", out_last, 0);
      chk("rst_m1re", out_m1_re, 0);
      rst = 1'b0;
      #1 chk("rst_wr_ready", wr_ready, 1);

      step(0, 0, 0, 0, 1, 0);
      for (int k = 0; k < NN; k++)
         step(1, 0, W'(k + 1), W'(k + 5), 0, 0);
      step(0, 0, 0, 0, 1, 0);
      step(1, 0, 16'd99, 16'd99, 0, 0);
      for (int k = 0; k < NN - 1; k++)
         step(1, 1, W'(k + 9), W'(k + 13), 0, 0);
      step(1, 1, 16'd12, 16'd16, 1, 0);

      step(0, 0, 0, 0, 1, 0);
      drain(0, NN);
      step(0, 0, 0, 0, 1, 0);
      drain(2, NN + 3);
      step(0, 0, 0, 0, 1, 0);
      drain(1, -1);

      step(0, 0, 0, 0, 1, 0);
      out_ready = 1'b1;
      @(posedge clk);
      #1 chk("rst_at_col", out_col, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b0;
      wr_sel = 1'b0;
      q.delete();
      model_clear();
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_full", {m1_full, m2_full}, 0);
      chk("mid_rst_col", out_col, 0);
      #1 chk("mid_rst_wr_ready", wr_ready, 1);

      step(1, 0, 16'h7777, 16'h7777, 0, 1);
      load_rand();
      step(0, 0, 0, 0, 1, 0);
      drain(1, -1);

      step(0, 0, 0, 0, 1, 1);
      load_rand();
      step(0, 0, 0, 0, 1, 0);
      out_ready = 1'b1;
      @(posedge clk);
      #1 clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      out_ready = 1'b0;
      q.delete();
      model_clear();
      chk("clr_abort_valid", out_valid, 0);
      chk("clr_abort_busy", busy, 0);
      chk("clr_abort_full", {m1_full, m2_full}, 0);

      for (int r = 0; r < 3; r++) begin
         load_rand();
         step(0, 0, 0, 0, 1, 0);
         drain(1, -1);
         step(0, 0, 0, 0, 1, 0);
         drain(0, NN);
      end

      chk("queue_empty", q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/cmat_ram_bank.md
CMAT_RAM_BANK -- requirements
Module: cmat_ram_bank

Interface
REQ-001 Parameter WORD_LEN, default 16: bits per real or imaginary element.
REQ-002 Parameter MATRIX_DIM, default 4: square matrix dimension N; legal values are 2 and above.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 clr  input  1  one-cycle pulse: clears both load counters and both full flags; stored data is kept.
REQ-006 wr_valid  input  1  write beat offered.
REQ-007 wr_ready  output  1  write beat accepted this cycle when wr_valid is also high.
REQ-008 wr_sel  input  1  target matrix: 0 = M1, 1 = M2.
REQ-009 wr_re / wr_im  input  WORD_LEN each  separate real and imaginary data of one element.
REQ-010 m1_full / m2_full  output  1 each  all N*N elements of that matrix are loaded.
REQ-011 start  input  1  one-cycle pulse that requests the product-operand stream.
REQ-012 busy  output  1  high while in STREAM.
REQ-013 out_valid  output  1  an operand beat is presented.
REQ-014 out_ready  input  1  consumer accepts the beat.
REQ-015 out_m1_re / out_m1_im  output  WORD_LEN*MATRIX_DIM each  row i of M1; element k at bits [k*WORD_LEN +: WORD_LEN].
REQ-016 out_m2_re / out_m2_im  output  WORD_LEN*MATRIX_DIM each  column j of M2; element k = M2[k][j], same packing.
REQ-017 out_row / out_col  output  clog2(MATRIX_DIM) each  indices i and j of the current beat.
REQ-018 out_last  output  1  the current beat is i = j = N-1.

Function
REQ-019 Storage: four planes (M1 real, M1 imag, M2 real, M2 imag), each N*N words in register or inferred RAM; real and imaginary data are written independently.
REQ-020 FSM states: IDLE and STREAM only.
REQ-021 IDLE: wr_ready = 1 when the matrix selected by wr_sel has its full flag low; otherwise wr_ready = 0.
REQ-022 STREAM: wr_ready = 0.
REQ-023 Load order: each matrix has its own load counter 0..N*N-1, row-major (address = r*N + c); an accepted beat writes both planes at the counter address, then increments the counter.
REQ-024 Full flag: accepting the beat at address N*N-1 sets that matrix's full flag and wraps its counter to 0.
REQ-025 Writes offered while wr_ready = 0 are dropped, with no change to any state.
REQ-026 IDLE->STREAM: on start when m1_full and m2_full are both high before the current edge (registered values); otherwise start is ignored.
REQ-027 Stream entry: (i, j) is set to (0, 0); out_valid rises on the cycle after start (latency 1).
REQ-028 Beat order: j increments fastest, i slower; a beat advances only when out_valid and out_ready are both high.
REQ-029 Stall: while out_valid = 1 and out_ready = 0, all out_* signals hold stable.
REQ-030 Output registers: every out_* signal is registered; out_ready has no combinational path to any output.
REQ-031 STREAM->IDLE: on acceptance of the out_last beat; out_valid = 0 in the next cycle.
REQ-032 After a stream: full flags stay set, so a new start replays the same operands.
REQ-033 clr: honoured in any state; in STREAM it also aborts the stream (out_valid = 0 next cycle, state goes to IDLE).
REQ-034 Simultaneous clr and start: clr wins and start is ignored.
REQ-035 Simultaneous write and clr: the write is dropped.
REQ-036 Simultaneous final write and start: the write is accepted, but start is ignored because the full flag was still low.

Reset
REQ-037 rst, effective in any state including mid-stream: FSM to IDLE; counters, i and j to 0; m1_full, m2_full, busy, out_valid and out_last to 0.
REQ-038 rst also clears out_m1_*, out_m2_*, out_row and out_col to 0; stored matrix contents are undefined after rst.
REQ-039 wr_ready after reset: 1 in the first cycle after rst is deasserted.

Verification
REQ-040 N=2, WORD_LEN=16: load M1 re = 1,2,3,4 and im = 5,6,7,8; load M2 re = 9..12 and im = 13..16; then start with out_ready = 1. Required: 4 beats on consecutive cycles, starting 1 cycle after start. Beat (0,1) carries out_m1_re = {2,1} and out_m2_re = {12,10}. out_last is high only on beat (1,1).
REQ-041 Backpressure: hold out_ready = 0 for 3 cycles on beat (1,0). Required: outputs stable throughout; no beat lost or duplicated.
REQ-042 Start with only m1_full set. Required: busy stays 0 and out_valid stays 0.
REQ-043 Fifth write to full M1 (N=2). Required: wr_ready = 0 and M1 contents unchanged. A fresh stream replays identical data.
REQ-044 rst asserted on beat (0,1). Required: next cycle out_valid = 0, busy = 0 and both full flags = 0; wr_ready = 1 on the following cycle.
REQ-045 clr and start in the same cycle with both matrices full. Required: no stream occurs and both full flags are 0.
